data_memory_pipe: RTL and testbench
===================================

Name: data_memory_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle CPU data memory.
- Adds byte addressing, MIPS sub-word loads and stores (lb/lbu/lh/lhu/lw/sb/sh/sw), a valid/ready request port and a configurable read latency.
- Detects misaligned, out-of-range and reserved-size accesses and logs them.
- Sits between the CPU memory stage and the data array; a future multi-cycle/pipelined core uses it as its load/store unit back end.

Parameters:
- DATA_WIDTH, 32, data bus width; fixed at 32 for this revision, checked by an elaboration-time assertion.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_WORDS, 8192, number of 32-bit words in the array; power of two.
- READ_LATENCY, 1, cycles from request acceptance to response; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- resp_valid  out  1  response present (one-cycle pulse per request)
- resp_write  out  1  response belongs to a store
- resp_data  out  DATA_WIDTH  extended load data; 0 for stores and for errors
- resp_err  out  1  request faulted
- err_sticky  out  1  a fault has occurred since the last clear
- err_addr  out  ADDR_WIDTH  address of the first fault since the last clear
- err_clear  in  1  clears err_sticky and err_addr

Behaviour:
- Reset:
  - One clock; rst_n is asynchronous and active-low.
  - While rst_n = 0: req_ready, resp_valid, resp_write, resp_err and err_sticky are 0; resp_data and err_addr are 0.
  - All pipeline valid bits clear; the memory array is not reset.
  - req_ready rises on the first clk edge after rst_n deasserts, then stays 1.
- Accept: a request is accepted on a rising edge with req_valid & req_ready. One request per cycle is allowed, with no bubbles.
- Address decode:
  - word index = req_addr[ADDR_WIDTH-1:2]; lane = req_addr[1:0].
  - Little-endian: byte lane k occupies bits 8k+7:8k.
- Fault conditions (any one faults the request):
  - size 3;
  - half access with lane[0] = 1;
  - word access with lane != 0;
  - word index >= DEPTH_WORDS.
- Faulted request: no array write. The response still occurs with resp_err = 1 and resp_data = 0.
- Stores:
  - Array updated at the accepting edge; only the addressed lanes change.
  - sb writes req_wdata[7:0] into lane; sh writes req_wdata[15:0] into lanes lane, lane+1; sw writes all 4 lanes.
- Loads:
  - The array is read at the accepting edge, so a load accepted the cycle after a store to the same word sees the new data.
  - The selected byte or half is right-aligned, then sign- or zero-extended per req_unsigned; req_unsigned is ignored for word loads.
- Latency and ordering:
  - Every accepted request (load, store or faulted) produces exactly one response exactly READ_LATENCY cycles after acceptance.
  - Responses return in order.
  - Response fields are registered in a READ_LATENCY-deep shift pipeline carrying valid, write, err and data.
  - resp_data, resp_write and resp_err are 0 when resp_valid = 0.
- Error log:
  - On the first fault while err_sticky = 0: err_sticky sets at the accepting edge and err_addr captures req_addr.
  - Later faults do not overwrite err_addr.
  - err_clear = 1 clears both at the edge.
  - If a new fault and err_clear fall on the same edge, the fault wins: err_sticky = 1 and err_addr = the new address.
- Reset mid-operation: in-flight responses are discarded and never appear. Stores already accepted remain in the array.
- Boundaries:
  - The last word (index DEPTH_WORDS-1) is legal; index DEPTH_WORDS faults.
  - Address bits above the array index are not aliased; they fault.

Test Plan:
- Reset, then sw 0x1234_5678 @ 0x10, then lw @ 0x10 on the next cycle (READ_LATENCY = 1):
  - the store response is resp_valid with resp_write = 1, resp_data = 0;
  - one cycle later the load response is resp_data = 0x1234_5678.
- Sub-word loads from word @ 0x20 = 0x80FF_7F01:
  - lb @ 0x23 -> 0xFFFF_FF80; lbu @ 0x23 -> 0x0000_0080;
  - lh @ 0x22 -> 0xFFFF_80FF; lhu @ 0x20 -> 0x0000_7F01.
- Sub-word stores: sb 0xAA @ 0x21, then sh 0xBEEF @ 0x22, both onto 0x0000_0000 -> lw @ 0x20 returns 0xBEEF_AA00.
- Back-to-back loads to 0x0, 0x4, 0x8 on three consecutive cycles with READ_LATENCY = 3 -> three responses on consecutive cycles, in order, starting 3 cycles after the first acceptance.
- Faults:
  - lw @ 0x6 -> resp_err = 1, resp_data = 0, err_sticky = 1, err_addr = 0x6;
  - sh @ 0x8001 then sw @ (DEPTH_WORDS*4) -> err_addr stays 0x6;
  - err_clear together with a size-3 request @ 0x40 -> err_sticky = 1, err_addr = 0x40.
- Mid-operation reset: issue lw, then assert rst_n = 0 before the response -> no resp_valid after reset release; req_ready returns to 1 one cycle after release; an earlier sw value is still readable.

Source files
------------

// File: rtl/data_memory_pipe.sv
// data_memory_pipe
// Pipelined, byte-addressed data memory back end for the CPU load/store path.
// It supports MIPS sub-word accesses (lb/lbu/lh/lhu/lw/sb/sh/sw) and has a
// valid/ready request port and a fixed response latency of READ_LATENCY cycles.
// Faulting requests (reserved size, misaligned, out of range) get a response
// with resp_err set. The first fault since the last clear is logged.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   request handshake; accepted when both are high
//   req_write               1 = store, 0 = load
//   req_size                0 = byte, 1 = half, 2 = word, 3 = reserved (faults)
//   req_unsigned            zero-extend sub-word loads when 1
//   req_addr                byte address (little-endian lanes)
//   req_wdata               store data, right-aligned
//   resp_valid              one-cycle pulse per accepted request
//   resp_write              response belongs to a store
//   resp_data               extended load data; 0 for stores and for faults
//   resp_err                request faulted
//   err_sticky, err_addr    fault log: flag and first faulting address
//   err_clear               clears the fault log (a same-edge fault wins)
module data_memory_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 8192,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_write,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  err_sticky,
  output logic [ADDR_WIDTH-1:0] err_addr,
  input  logic                  err_clear
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Elaboration-time parameter checks.
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("data_memory_pipe: DATA_WIDTH must be 32");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("data_memory_pipe: READ_LATENCY must be 1..4");
  end
  if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("data_memory_pipe: DEPTH_WORDS must be a power of two");
  end
  if (ADDR_WIDTH <= IDX_W + 2) begin : g_bad_addr
    $error("data_memory_pipe: ADDR_WIDTH must exceed the array index plus lane bits");
  end

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic [1:0]       lane;
  logic [IDX_W-1:0] mem_idx;
  logic             range_err;
  logic             fault;
  logic [3:0]       be;
  logic [31:0]      wd;
  logic [31:0]      rword;
  logic [31:0]      shifted;
  logic [31:0]      load_data;

  assign accept  = req_valid & req_ready;
  assign lane    = req_addr[1:0];
  assign mem_idx = req_addr[IDX_W+1:2];
  // Any set bit above the array index means the word index is at or past
  // DEPTH_WORDS. These addresses fault instead of wrapping onto low words.
  assign range_err = |req_addr[ADDR_WIDTH-1:IDX_W+2];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    fault = range_err;
    case (req_size)
      2'd1:    if (lane[0])       fault = 1'b1;
      2'd2:    if (lane != 2'd0)  fault = 1'b1;
      2'd3:                       fault = 1'b1;
      default: ;
    endcase
  end

  // Store lane enables. The data is replicated across lanes so the enables
  // alone pick which bytes land.
  always_comb begin
    be = 4'b0000;
    wd = req_wdata;
    case (req_size)
      2'd0: begin be = 4'b0001 << lane; wd = {4{req_wdata[7:0]}};  end
      2'd1: begin be = 4'b0011 << lane; wd = {2{req_wdata[15:0]}}; end
      2'd2: begin be = 4'b1111;         wd = req_wdata;            end
      default: ;
    endcase
    if (!(accept && req_write && !fault)) be = 4'b0000;
  end

  // NOTE: the data array has no reset; only control state is cleared by rst_n.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (be[k]) mem[mem_idx][8*k +: 8] <= wd[8*k +: 8];
    end
  end

  // The array is read when the request is accepted. A store accepted on the
  // previous edge is already in the array at that point.
  always_comb begin
    rword     = mem[mem_idx];
    shifted   = rword >> {lane, 3'b000};
    load_data = 32'd0;
    case (req_size)
      2'd0: load_data = req_unsigned ? {24'd0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      2'd1: load_data = req_unsigned ? {16'd0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      2'd2: load_data = rword;
      default: ;
    endcase
    if (fault || req_write) load_data = 32'd0;
  end

  // Response shift pipeline. Stage 0 is loaded at the accepting edge. All
  // fields are forced to zero when no request was accepted, so idle responses
  // read as zero.
  logic [READ_LATENCY-1:0] pv, pw, pe;
  logic [31:0]             pd [READ_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      pv <= '0;
      pw <= '0;
      pe <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pd[k] <= 32'd0;
    end else begin
      pv[0] <= accept;
      pw[0] <= accept & req_write;
      pe[0] <= accept & fault;
      pd[0] <= accept ? load_data : 32'd0;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pv[k] <= pv[k-1];
        pw[k] <= pw[k-1];
        pe[k] <= pe[k-1];
        pd[k] <= pd[k-1];
      end
    end
  end

  assign resp_valid = pv[READ_LATENCY-1];
  assign resp_write = pw[READ_LATENCY-1];
  assign resp_err   = pe[READ_LATENCY-1];
  assign resp_data  = pd[READ_LATENCY-1];

  // req_ready is held low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_ready <= 1'b0;
    else        req_ready <= 1'b1;
  end

  // Fault log. A new fault on the same edge as err_clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end else if (accept && fault && (!err_sticky || err_clear)) begin
      err_sticky <= 1'b1;
      err_addr   <= req_addr;
    end else if (err_clear) begin
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end
  end

endmodule

// File: tb/tb_data_memory_pipe.sv
// Testbench for data_memory_pipe. It drives one stimulus stream into two
// instances, with READ_LATENCY = 1 and READ_LATENCY = 3. A byte-level memory
// model computes the expected responses. Each expected response goes into a
// per-instance queue, tagged with the cycle it is due in.
module tb_data_memory_pipe;

  localparam int DEPTH = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_unsigned, err_clear;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        r1_ready, r1_valid, r1_write, r1_err, r1_sticky;
  logic [31:0] r1_data, r1_eaddr;
  logic        r3_ready, r3_valid, r3_write, r3_err, r3_sticky;
  logic [31:0] r3_data, r3_eaddr;

  always #5 clk = ~clk;

  data_memory_pipe #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r1_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(r1_valid),
    .resp_write(r1_write), .resp_data(r1_data), .resp_err(r1_err),
    .err_sticky(r1_sticky), .err_addr(r1_eaddr), .err_clear(err_clear));

  data_memory_pipe #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r3_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(r3_valid),
    .resp_write(r3_write), .resp_data(r3_data), .resp_err(r3_err),
    .err_sticky(r3_sticky), .err_addr(r3_eaddr), .err_clear(err_clear));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        write;
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  logic [7:0]  mbytes [int];
  logic        m_sticky;
  logic [31:0] m_eaddr;

  function automatic logic [7:0] mb(input logic [31:0] a);
    return mbytes.exists(int'(a)) ? mbytes[int'(a)] : 8'h00;
  endfunction

  function automatic logic is_fault(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
           || ((a >> 2) >= 32'(DEPTH));
  endfunction

  // Drive one request. The model is updated and expectations are queued here.
  task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wdat,
                       input logic clr = 1'b0);
    exp_t        e;
    logic        f;
    logic [31:0] v;
    logic [15:0] h;
    @(negedge clk);
    check("ready1", {31'd0, r1_ready}, 32'd1);
    check("ready3", {31'd0, r3_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wdat; err_clear = clr;
    f = is_fault(sz, a);
    v = 32'd0;
    if (!f && wr) begin
      for (int i = 0; i < (1 << sz); i++) mbytes[int'(a) + i] = wdat[8*i +: 8];
    end else if (!f) begin
      case (sz)
        2'd0: v = uns ? {24'd0, mb(a)} : {{24{mb(a)[7]}}, mb(a)};
        2'd1: begin
          h = {mb(a + 1), mb(a)};
          v = uns ? {16'd0, h} : {{16{h[15]}}, h};
        end
        default: v = {mb(a + 3), mb(a + 2), mb(a + 1), mb(a)};
      endcase
    end
    if (f && (!m_sticky || clr)) begin
      m_sticky = 1'b1; m_eaddr = a;
    end else if (clr) begin
      m_sticky = 1'b0; m_eaddr = 32'd0;
    end
    e.write = wr; e.err = f; e.data = v;
    e.due = cyc + 1; q1.push_back(e);
    e.due = cyc + 3; q3.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0; err_clear = 1'b0;
    end
  endtask

  task automatic check_err(input string tag);
    check({tag, "_sticky1"}, {31'd0, r1_sticky}, {31'd0, m_sticky});
    check({tag, "_addr1"}, r1_eaddr, m_eaddr);
    check({tag, "_sticky3"}, {31'd0, r3_sticky}, {31'd0, m_sticky});
    check({tag, "_addr3"}, r3_eaddr, m_eaddr);
  endtask

  // Response monitors, sampled on the falling edge.
  always @(negedge clk) if (rst_n) begin
    if (r1_valid) begin
      if (q1.size() == 0) check("l1_unexpected_resp", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("l1_cycle", cyc, e1.due);
        check("l1_data", r1_data, e1.data);
        check("l1_write", {31'd0, r1_write}, {31'd0, e1.write});
        check("l1_err", {31'd0, r1_err}, {31'd0, e1.err});
      end
    end else begin
      if (q1.size() > 0 && q1[0].due <= cyc) begin
        check("l1_missing_resp", cyc, q1[0].due);
        void'(q1.pop_front());
      end
      check("l1_idle_zero", r1_data | {30'd0, r1_write, r1_err}, 32'd0);
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (r3_valid) begin
      if (q3.size() == 0) check("l3_unexpected_resp", 32'd1, 32'd0);
      else begin
        e3 = q3.pop_front();
        check("l3_cycle", cyc, e3.due);
        check("l3_data", r3_data, e3.data);
        check("l3_write", {31'd0, r3_write}, {31'd0, e3.write});
        check("l3_err", {31'd0, r3_err}, {31'd0, e3.err});
      end
    end else begin
      if (q3.size() > 0 && q3[0].due <= cyc) begin
        check("l3_missing_resp", cyc, q3[0].due);
        void'(q3.pop_front());
      end
      check("l3_idle_zero", r3_data | {30'd0, r3_write, r3_err}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; err_clear = 1'b0;
    m_sticky = 1'b0; m_eaddr = 32'd0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {30'd0, r1_ready, r3_ready}, 32'd0);
    check("rst_valid", {30'd0, r1_valid, r3_valid}, 32'd0);
    check("rst_sticky", {30'd0, r1_sticky, r3_sticky}, 32'd0);
    check("rst_eaddr", r1_eaddr | r3_eaddr, 32'd0);
    check("rst_resp", r1_data | r3_data | {30'd0, r1_write | r1_err, r3_write | r3_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Store followed immediately by a load of the same word.
    drive(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678);
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    idle(4);

    // Sub-word loads.
    drive(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF_7F01);
    drive(1'b0, 2'd0, 1'b0, 32'h23, 32'h0);
    drive(1'b0, 2'd0, 1'b1, 32'h23, 32'h0);
    drive(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    drive(1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
    drive(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
    drive(1'b0, 2'd1, 1'b0, 32'h20, 32'h0);
    idle(4);

    // Sub-word stores onto a zeroed word.
    drive(1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
    drive(1'b1, 2'd0, 1'b0, 32'h21, 32'h5555_55AA);
    drive(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_BEEF);
    drive(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    idle(4);

    // Back-to-back loads.
    drive(1'b1, 2'd2, 1'b0, 32'h0, 32'hA0A0_0000);
    drive(1'b1, 2'd2, 1'b0, 32'h4, 32'hB1B1_0004);
    drive(1'b1, 2'd2, 1'b0, 32'h8, 32'hC2C2_0008);
    drive(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    drive(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    idle(5);

    // Last legal word.
    drive(1'b1, 2'd2, 1'b0, 32'((DEPTH - 1) * 4), 32'hFEED_F00D);
    drive(1'b0, 2'd2, 1'b0, 32'((DEPTH - 1) * 4), 32'h0);
    idle(4);
    check_err("no_fault");

    // Faults and the error log.
    drive(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
    idle(1);
    check_err("first_fault");
    drive(1'b1, 2'd1, 1'b0, 32'h8001, 32'h0000_DEAD);
    drive(1'b1, 2'd2, 1'b0, 32'(DEPTH * 4), 32'hDEAD_BEEF);
    drive(1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0);
    drive(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    idle(1);
    check_err("later_faults");
    drive(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 1'b1);
    idle(1);
    check_err("clear_vs_fault");
    @(negedge clk);
    err_clear = 1'b1;
    m_sticky = 1'b0; m_eaddr = 32'd0;
    idle(1);
    check_err("clear_only");
    idle(4);

    // Reset while a load is in flight.
    drive(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFE_F00D);
    drive(1'b1, 2'd1, 1'b0, 32'h45, 32'h0);
    drive(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = 1'b0;
    void'(q1.pop_front()); void'(q1.pop_front());
    void'(q3.pop_front()); void'(q3.pop_front());
    q1.delete(); q3.delete();
    m_sticky = 1'b0; m_eaddr = 32'd0;
    @(negedge clk);
    check("midrst_ready", {30'd0, r1_ready, r3_ready}, 32'd0);
    check("midrst_valid", {30'd0, r1_valid, r3_valid}, 32'd0);
    check("midrst_sticky", {30'd0, r1_sticky, r3_sticky}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("release_ready_low", {30'd0, r1_ready, r3_ready}, 32'd0);
    @(negedge clk);
    check("release_ready_high", {30'd0, r1_ready, r3_ready}, 32'd3);
    idle(4);
    drive(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    idle(1);

    // Drain the queues within a bounded number of cycles.
    for (int i = 0; i < 20 && (q1.size() + q3.size()) != 0; i++) @(negedge clk);
    check("drain_q1", q1.size(), 32'd0);
    check("drain_q3", q3.size(), 32'd0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
